// File: rtl/pinball_game_ctrl_if.sv
// -----------------------------------------------------------------------------
// pinball_game_ctrl_if
// Bundles the game sequencer's event inputs and its registered outputs.
//   master : drives start_btn / hit / hit_group, observes the game outputs
//   slave  : the sequencer itself
// Signals:
//   start_btn       one-cycle debounced start/restart pulse
//   hit             one-cycle target-struck pulse
//   hit_group[2:0]  struck target group, qualified by hit
//   led_tick        one-cycle strobe to the LED controller led_clk
//   state[2:0]      game state (RESET=0 WAIT=1 START=2 GET=3 OVER=4)
//   selected_group  active target group, 0..7 zero-extended to 8 bits
//   score[7:0]      hits this game, saturating
//   balls_left[1:0] balls remaining
// -----------------------------------------------------------------------------
interface pinball_game_ctrl_if;
  logic       start_btn;
  logic       hit;
  logic [2:0] hit_group;
  logic       led_tick;
  logic [2:0] state;
  logic [7:0] selected_group;
  logic [7:0] score;
  logic [1:0] balls_left;

  modport master (
    output start_btn, hit, hit_group,
    input  led_tick, state, selected_group, score, balls_left
  );

  modport slave (
    input  start_btn, hit, hit_group,
    output led_tick, state, selected_group, score, balls_left
  );
endinterface

// File: rtl/pinball_game_ctrl.sv
// -----------------------------------------------------------------------------
// pinball_game_ctrl
// Top-level game sequencer: game FSM, LED tick prescaler, ball and score
// tracking. All outputs are registered.
// Ports:
//   clk    system clock
//   reset  synchronous, active-high
//   bus    pinball_game_ctrl_if.slave (events in, game state out)
//
// state | meaning
// ------+----------------------------------------------------------
// RESET | attract mode, waits for start_btn
// WAIT  | ball being served, WAIT_TICKS led_ticks
// START | round running, target group rotates every led_tick
// GET   | hit celebration, GET_TICKS led_ticks, group frozen
// OVER  | no balls left, score held until start_btn
// -----------------------------------------------------------------------------
module pinball_game_ctrl #(
  parameter int TICK_DIV    = 4,
  parameter int WAIT_TICKS  = 8,
  parameter int ROUND_TICKS = 16,
  parameter int GET_TICKS   = 4,
  parameter int MAX_BALLS   = 3
) (
  input logic                clk,
  input logic                reset,
  pinball_game_ctrl_if.slave bus
);

  localparam logic [2:0] S_RESET = 3'd0;
  localparam logic [2:0] S_WAIT  = 3'd1;
  localparam logic [2:0] S_START = 3'd2;
  localparam logic [2:0] S_GET   = 3'd3;
  localparam logic [2:0] S_OVER  = 3'd4;

  localparam int PRE_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

  localparam int MAX_WR = (WAIT_TICKS > ROUND_TICKS) ? WAIT_TICKS : ROUND_TICKS;
  localparam int MAX_T  = (MAX_WR > GET_TICKS) ? MAX_WR : GET_TICKS;
  localparam int CNT_W  = $clog2(MAX_T + 1);

  localparam logic [CNT_W-1:0] WAIT_LAST  = CNT_W'(WAIT_TICKS - 1);
  localparam logic [CNT_W-1:0] ROUND_LAST = CNT_W'(ROUND_TICKS - 1);
  localparam logic [CNT_W-1:0] GET_LAST   = CNT_W'(GET_TICKS - 1);
  localparam logic [CNT_W-1:0] CNT_SAT    = {CNT_W{1'b1}};

  logic [PRE_W-1:0] r_presc;
  logic             r_led_tick;
  logic [2:0]       r_state;
  logic [CNT_W-1:0] r_tick_cnt;
  logic [2:0]       r_sel;
  logic [7:0]       r_score;
  logic [1:0]       r_balls;

  logic [2:0]       w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [2:0]       w_sel_nxt;
  logic [7:0]       w_score_nxt;
  logic [1:0]       w_balls_nxt;
  logic             w_match;
  logic             w_wait_done;
  logic             w_round_done;
  logic             w_get_done;

  // Free-running prescaler; led_tick is the registered terminal-count flag,
  // so the first pulse lands on the TICK_DIV-th edge after reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_presc    <= '0;
      r_led_tick <= 1'b0;
    end else if (r_presc == PRE_LAST) begin
      r_presc    <= '0;
      r_led_tick <= 1'b1;
    end else begin
      r_presc    <= r_presc + 1'b1;
      r_led_tick <= 1'b0;
    end
  end

  assign w_match      = bus.hit && (bus.hit_group == r_sel);
  assign w_wait_done  = r_led_tick && (r_tick_cnt == WAIT_LAST);
  assign w_round_done = r_led_tick && (r_tick_cnt == ROUND_LAST);
  assign w_get_done   = r_led_tick && (r_tick_cnt == GET_LAST);

  // State register
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_RESET;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_RESET: if (bus.start_btn) w_state_nxt = S_WAIT;
      S_WAIT:  if (w_wait_done)   w_state_nxt = S_START;
      S_START: begin
        // A matching hit beats a coincident timeout.
        if (w_match)           w_state_nxt = S_GET;
        else if (w_round_done) w_state_nxt = (r_balls <= 2'd1) ? S_OVER : S_WAIT;
      end
      S_GET:   if (w_get_done)    w_state_nxt = S_START;
      S_OVER:  if (bus.start_btn) w_state_nxt = S_RESET;
      default: w_state_nxt = S_RESET;
    endcase
  end

  // Output / datapath next values
  always_comb begin
    w_sel_nxt   = r_sel;
    w_score_nxt = r_score;
    w_balls_nxt = r_balls;

    // Tick counter restarts on any state change, otherwise saturates.
    if (w_state_nxt != r_state)
      w_cnt_nxt = '0;
    else if (r_led_tick && (r_tick_cnt != CNT_SAT))
      w_cnt_nxt = r_tick_cnt + 1'b1;
    else
      w_cnt_nxt = r_tick_cnt;

    case (r_state)
      S_RESET: begin
        w_sel_nxt = '0;
        if (bus.start_btn) begin
          w_score_nxt = '0;
          w_balls_nxt = 2'(MAX_BALLS);
        end
      end
      S_WAIT: begin
        if (w_wait_done) w_sel_nxt = '0;
      end
      S_START: begin
        if (w_match) begin
          if (r_score != 8'hFF) w_score_nxt = r_score + 8'd1;
        end else begin
          if (r_led_tick)   w_sel_nxt = r_sel + 3'd1;
          if (w_round_done) w_balls_nxt = (r_balls != 2'd0) ? r_balls - 2'd1 : 2'd0;
        end
      end
      S_GET: begin
      end
      S_OVER: begin
        if (bus.start_btn) w_sel_nxt = '0;
      end
      default: begin
        w_sel_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_tick_cnt <= '0;
      r_sel      <= '0;
      r_score    <= '0;
      r_balls    <= '0;
    end else begin
      r_tick_cnt <= w_cnt_nxt;
      r_sel      <= w_sel_nxt;
      r_score    <= w_score_nxt;
      r_balls    <= w_balls_nxt;
    end
  end

  assign bus.led_tick       = r_led_tick;
  assign bus.state          = r_state;
  assign bus.selected_group = {5'd0, r_sel};
  assign bus.score          = r_score;
  assign bus.balls_left     = r_balls;

endmodule

// File: tb/tb_pinball_game_ctrl.sv
module tb_pinball_game_ctrl;
  localparam int TICK_DIV    = 4;
  localparam int WAIT_TICKS  = 8;
  localparam int ROUND_TICKS = 16;
  localparam int GET_TICKS   = 4;
  localparam int MAX_BALLS   = 3;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  int   n_checks = 0;
  int   n_pass   = 0;

  pinball_game_ctrl_if bus();

  pinball_game_ctrl #(
    .TICK_DIV(TICK_DIV), .WAIT_TICKS(WAIT_TICKS), .ROUND_TICKS(ROUND_TICKS),
    .GET_TICKS(GET_TICKS), .MAX_BALLS(MAX_BALLS)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Reference model: game rules applied per clock edge with plain integers.
  // The LED tick is derived from the absolute count of edges since reset.
  int m_cyc = 0, m_phase = 0, m_cnt = 0, m_sel = 0, m_score = 0, m_balls = 0;
  bit m_tick = 0;

  always @(posedge clk) begin
    if (reset) begin
      m_cyc = 0; m_phase = 0; m_cnt = 0; m_sel = 0; m_score = 0; m_balls = 0; m_tick = 0;
    end else begin
      case (m_phase)
        0: begin
          m_sel = 0;
          if (bus.start_btn) begin m_phase = 1; m_score = 0; m_balls = MAX_BALLS; m_cnt = 0; end
        end
        1: if (m_tick) begin
          if (m_cnt == WAIT_TICKS - 1) begin m_phase = 2; m_sel = 0; m_cnt = 0; end
          else m_cnt++;
        end
        2: begin
          if (bus.hit && (int'(bus.hit_group) == m_sel)) begin
            m_phase = 3; m_cnt = 0;
            m_score = (m_score < 255) ? m_score + 1 : 255;
          end else if (m_tick) begin
            m_sel = (m_sel + 1) % 8;
            if (m_cnt == ROUND_TICKS - 1) begin
              m_phase = (m_balls == 1) ? 4 : 1;
              m_balls = m_balls - 1;
              m_cnt = 0;
            end else m_cnt++;
          end
        end
        3: if (m_tick) begin
          if (m_cnt == GET_TICKS - 1) begin m_phase = 2; m_cnt = 0; end
          else m_cnt++;
        end
        default: if (bus.start_btn) begin m_phase = 0; m_sel = 0; m_cnt = 0; end
      endcase
      m_cyc++;
      m_tick = (m_cyc % TICK_DIV) == 0;
    end
  end

  task automatic wait_state(input logic [2:0] s, input int limit, output bit ok);
    ok = 0;
    for (int i = 0; i < limit; i++) begin
      if (bus.state === s) begin ok = 1; break; end
      @(negedge clk);
    end
  endtask

  task automatic pulse_start();
    bus.start_btn = 1'b1;
    @(negedge clk);
    bus.start_btn = 1'b0;
  endtask

  task automatic test_reset();
    bit exp_tick;
    bus.start_btn = 0; bus.hit = 0; bus.hit_group = 0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++; if (bus.state !== 3'd0) $display("FAIL rst_state: got %0d want 0", bus.state); else n_pass++;
    n_checks++; if (bus.score !== 8'd0) $display("FAIL rst_score: got %0d want 0", bus.score); else n_pass++;
    n_checks++; if (bus.balls_left !== 2'd0) $display("FAIL rst_balls: got %0d want 0", bus.balls_left); else n_pass++;
    n_checks++; if (bus.selected_group !== 8'd0) $display("FAIL rst_sel: got %0d want 0", bus.selected_group); else n_pass++;
    n_checks++; if (bus.led_tick !== 1'b0) $display("FAIL rst_tick: got %0b want 0", bus.led_tick); else n_pass++;
    reset = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      exp_tick = (i % TICK_DIV) == 0;
      n_checks++; if (bus.led_tick !== exp_tick) $display("FAIL idle_tick clk%0d: got %0b want %0b", i, bus.led_tick, exp_tick); else n_pass++;
    end
    n_checks++; if (bus.state !== 3'd0) $display("FAIL idle_state: got %0d want 0", bus.state); else n_pass++;
    n_checks++; if (bus.score !== 8'd0 || bus.balls_left !== 2'd0) $display("FAIL idle_score_balls: got %0d/%0d want 0/0", bus.score, bus.balls_left); else n_pass++;
  endtask

  task automatic test_start_wait();
    int ticks, cyc;
    logic [7:0] prev, want;
    bit ok;
    pulse_start();
    n_checks++; if (bus.state !== 3'd1) $display("FAIL start_state: got %0d want 1", bus.state); else n_pass++;
    n_checks++; if (bus.balls_left !== 2'(MAX_BALLS)) $display("FAIL start_balls: got %0d want %0d", bus.balls_left, MAX_BALLS); else n_pass++;
    n_checks++; if (bus.score !== 8'd0) $display("FAIL start_score: got %0d want 0", bus.score); else n_pass++;
    ticks = 0; cyc = 0;
    while (bus.state === 3'd1 && cyc < 100) begin
      if (bus.led_tick) ticks++;
      @(negedge clk); cyc++;
    end
    n_checks++; if (bus.state !== 3'd2) $display("FAIL wait_exit_state: got %0d want 2", bus.state); else n_pass++;
    n_checks++; if (ticks != WAIT_TICKS) $display("FAIL wait_ticks: got %0d want %0d", ticks, WAIT_TICKS); else n_pass++;
    n_checks++; if (bus.selected_group !== 8'd0) $display("FAIL round_sel0: got %0d want 0", bus.selected_group); else n_pass++;
    for (int k = 1; k <= 8; k++) begin
      prev = bus.selected_group;
      ok = 0;
      for (int c = 0; c < 10; c++) begin
        @(negedge clk);
        if (bus.selected_group !== prev) begin ok = 1; break; end
      end
      want = 8'(k % 8);
      n_checks++; if (!ok || bus.selected_group !== want) $display("FAIL sel_step%0d: got %0d want %0d", k, bus.selected_group, want); else n_pass++;
    end
  endtask

  task automatic test_hit_get();
    int ticks, cyc;
    bit ok;
    ok = 0;
    for (int c = 0; c < 40; c++) begin
      if (bus.selected_group === 8'd5) begin ok = 1; break; end
      @(negedge clk);
    end
    n_checks++; if (!ok) $display("FAIL reach_sel5: got %0d want 5", bus.selected_group); else n_pass++;
    bus.hit = 1'b1; bus.hit_group = 3'd3;
    @(negedge clk);
    n_checks++; if (bus.state !== 3'd2 || bus.score !== 8'd0) $display("FAIL miss_ignored: got state %0d score %0d want 2/0", bus.state, bus.score); else n_pass++;
    bus.hit_group = 3'd5;
    @(negedge clk);
    bus.hit = 1'b0;
    n_checks++; if (bus.state !== 3'd3) $display("FAIL hit_state: got %0d want 3", bus.state); else n_pass++;
    n_checks++; if (bus.score !== 8'd1) $display("FAIL hit_score: got %0d want 1", bus.score); else n_pass++;
    ticks = 0; cyc = 0;
    while (bus.state === 3'd3 && cyc < 100) begin
      if (bus.led_tick) ticks++;
      @(negedge clk); cyc++;
    end
    n_checks++; if (ticks != GET_TICKS || bus.state !== 3'd2) $display("FAIL get_ticks: got %0d ticks state %0d want %0d/2", ticks, bus.state, GET_TICKS); else n_pass++;
    n_checks++; if (bus.selected_group !== 8'd5) $display("FAIL get_resume_sel: got %0d want 5", bus.selected_group); else n_pass++;
  endtask

  task automatic test_timeout();
    int ticks, cyc;
    logic [2:0] want_state;
    bit ok;
    for (int r = 0; r < 3; r++) begin
      ticks = 0; cyc = 0;
      while (bus.state === 3'd2 && cyc < 200) begin
        if (bus.led_tick) ticks++;
        @(negedge clk); cyc++;
      end
      want_state = (r == 2) ? 3'd4 : 3'd1;
      n_checks++; if (ticks != ROUND_TICKS) $display("FAIL round%0d_ticks: got %0d want %0d", r, ticks, ROUND_TICKS); else n_pass++;
      n_checks++; if (bus.state !== want_state) $display("FAIL round%0d_state: got %0d want %0d", r, bus.state, want_state); else n_pass++;
      n_checks++; if (bus.balls_left !== 2'(2 - r)) $display("FAIL round%0d_balls: got %0d want %0d", r, bus.balls_left, 2 - r); else n_pass++;
      n_checks++; if (bus.score !== 8'd1) $display("FAIL round%0d_score: got %0d want 1", r, bus.score); else n_pass++;
      if (r < 2) begin
        wait_state(3'd2, 60, ok);
        n_checks++; if (!ok) $display("FAIL round%0d_reserve: got state %0d want 2", r, bus.state); else n_pass++;
      end
    end
    repeat (5) @(negedge clk);
    n_checks++; if (bus.state !== 3'd4 || bus.score !== 8'd1) $display("FAIL over_hold: got state %0d score %0d want 4/1", bus.state, bus.score); else n_pass++;
    pulse_start();
    n_checks++; if (bus.state !== 3'd0) $display("FAIL over_restart: got %0d want 0", bus.state); else n_pass++;
  endtask

  task automatic test_coincident_and_reset();
    int ticks;
    logic [7:0] sel_exp;
    bit ok;
    pulse_start();
    wait_state(3'd2, 80, ok);
    n_checks++; if (!ok) $display("FAIL coin_reach_start: got %0d want 2", bus.state); else n_pass++;
    ticks = 0; ok = 0;
    for (int c = 0; c < 200; c++) begin
      if (bus.led_tick) ticks++;
      if (ticks == ROUND_TICKS) begin ok = 1; break; end
      @(negedge clk);
    end
    n_checks++; if (!ok) $display("FAIL coin_last_tick: got %0d ticks want %0d", ticks, ROUND_TICKS); else n_pass++;
    bus.hit = 1'b1; bus.hit_group = 3'(m_sel); sel_exp = 8'(m_sel);
    @(negedge clk);
    bus.hit = 1'b0;
    n_checks++; if (bus.state !== 3'd3) $display("FAIL coin_state: got %0d want 3", bus.state); else n_pass++;
    n_checks++; if (bus.balls_left !== 2'(MAX_BALLS)) $display("FAIL coin_balls: got %0d want %0d", bus.balls_left, MAX_BALLS); else n_pass++;
    n_checks++; if (bus.score !== 8'd1) $display("FAIL coin_score: got %0d want 1", bus.score); else n_pass++;
    n_checks++; if (bus.selected_group !== sel_exp) $display("FAIL coin_sel: got %0d want %0d", bus.selected_group, sel_exp); else n_pass++;
    for (int k = 2; k <= 7; k++) begin
      wait_state(3'd2, 80, ok);
      bus.hit = 1'b1; bus.hit_group = 3'(m_sel);
      @(negedge clk);
      bus.hit = 1'b0;
      n_checks++; if (!ok || bus.state !== 3'd3 || bus.score !== 8'(k)) $display("FAIL hit%0d: got state %0d score %0d want 3/%0d", k, bus.state, bus.score, k); else n_pass++;
    end
    reset = 1'b1;
    @(negedge clk);
    n_checks++; if (bus.state !== 3'd0 || bus.score !== 8'd0) $display("FAIL get_reset: got state %0d score %0d want 0/0", bus.state, bus.score); else n_pass++;
    n_checks++; if (bus.selected_group !== 8'd0 || bus.led_tick !== 1'b0 || bus.balls_left !== 2'd0) $display("FAIL get_reset_outs: got sel %0d tick %0b balls %0d want 0/0/0", bus.selected_group, bus.led_tick, bus.balls_left); else n_pass++;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_saturation();
    bit ok;
    int want;
    pulse_start();
    for (int k = 1; k <= 257; k++) begin
      wait_state(3'd2, 80, ok);
      bus.hit = 1'b1; bus.hit_group = 3'(m_sel);
      @(negedge clk);
      bus.hit = 1'b0;
      want = (k > 255) ? 255 : k;
      n_checks++; if (!ok || bus.score !== 8'(want)) $display("FAIL sat_score%0d: got %0d want %0d", k, bus.score, want); else n_pass++;
    end
    n_checks++; if (bus.balls_left !== 2'(MAX_BALLS)) $display("FAIL sat_balls: got %0d want %0d", bus.balls_left, MAX_BALLS); else n_pass++;
  endtask

  task automatic test_random();
    logic [20:0] got, want;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 6000; i++) begin
      @(negedge clk);
      got  = {bus.state, bus.selected_group, bus.score, bus.balls_left};
      want = {3'(m_phase), 8'(m_sel), 8'(m_score), 2'(m_balls)};
      n_checks++;
      if (got !== want || bus.led_tick !== m_tick)
        $display("FAIL random_cycle%0d: got st %0d sel %0d sc %0d b %0d t %0b want st %0d sel %0d sc %0d b %0d t %0b",
                 i, bus.state, bus.selected_group, bus.score, bus.balls_left, bus.led_tick,
                 m_phase, m_sel, m_score, m_balls, m_tick);
      else n_pass++;
      reset         = ($urandom_range(0, 1499) == 0);
      bus.start_btn = ($urandom_range(0, 29) == 0);
      bus.hit       = ($urandom_range(0, 24) == 0);
      bus.hit_group = ($urandom_range(0, 1) == 0) ? 3'(m_sel) : 3'($urandom_range(0, 7));
    end
    reset = 1'b0; bus.start_btn = 1'b0; bus.hit = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    bus.start_btn = 1'b0; bus.hit = 1'b0; bus.hit_group = 3'd0;
    test_reset();
    test_start_wait();
    test_hit_get();
    test_timeout();
    test_coincident_and_reset();
    test_saturation();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
